// File: rtl/sig_meter_pkg.sv
// Shared types and default constants for the signal meter.
package sig_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_MEASURE,
        ST_DONE
    } state_t;

    localparam logic signed [15:0] DEF_HYST           = 16'sd256;
    localparam int unsigned        DEF_WINDOW_PERIODS = 8;
    localparam int unsigned        DEF_TIMEOUT_CYCLES = 1_000_000;

endpackage

// File: rtl/sig_meter_schmitt_detect.sv
// Hysteresis comparator on accepted samples; o_rise flags the sample that flips LOW->HIGH.
module schmitt_detect
    import sig_meter_pkg::*;
#(
    parameter logic signed [15:0] HYST = DEF_HYST
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] i_data,
    input  logic               i_valid,
    output logic               o_rise
);

    logic               state_high;
    logic signed [16:0] data_ext;
    logic signed [16:0] hyst_pos;
    logic signed [16:0] hyst_neg;

    // 17-bit compare so that -HYST cannot overflow for large thresholds
    assign data_ext = {i_data[15], i_data};
    assign hyst_pos = {HYST[15], HYST};
    assign hyst_neg = -hyst_pos;

    assign o_rise = i_valid && !state_high && (data_ext >= hyst_pos);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_high <= 1'b0;
        end else if (i_valid) begin
            if (!state_high && (data_ext >= hyst_pos)) begin
                state_high <= 1'b1;
            end else if (state_high && (data_ext <= hyst_neg)) begin
                state_high <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sig_meter.sv
// Measures the span of WINDOW_PERIODS signal periods plus signed min/max over that window.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for i_start
// ST_ARM     | waiting for the first rising crossing
// ST_MEASURE | counting clk cycles and tracking min/max until the last crossing
// ST_DONE    | results just registered, o_valid high for this one cycle
module sig_meter
    import sig_meter_pkg::*;
#(
    parameter logic signed [15:0] HYST           = DEF_HYST,
    parameter int unsigned        WINDOW_PERIODS = DEF_WINDOW_PERIODS,
    parameter int unsigned        TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] i_data,
    input  logic               i_valid,
    input  logic               i_start,
    output logic [31:0]        o_period,
    output logic signed [15:0] o_min,
    output logic signed [15:0] o_max,
    output logic               o_valid,
    output logic               o_timeout,
    output logic               o_busy
);

    localparam logic [31:0] TMO_RELOAD = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  LAST_CROSS = 8'(WINDOW_PERIODS - 1);

    state_t             state;
    logic [31:0]        period_cnt;
    logic [31:0]        period_inc;
    logic [7:0]         cross_cnt;
    logic [31:0]        tmo_cnt;
    logic signed [15:0] min_r;
    logic signed [15:0] max_r;
    logic signed [15:0] min_nxt;
    logic signed [15:0] max_nxt;
    logic               rise;

    schmitt_detect #(.HYST(HYST)) u_schmitt (
        .clk     (clk),
        .rst     (rst),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_rise  (rise)
    );

    assign period_inc = (period_cnt == '1) ? period_cnt : period_cnt + 32'd1;
    assign min_nxt    = (i_valid && (i_data < min_r)) ? i_data : min_r;
    assign max_nxt    = (i_valid && (i_data > max_r)) ? i_data : max_r;
    assign o_busy     = (state == ST_ARM) || (state == ST_MEASURE);

    // Timeout is a down-counter reloaded on ARM entry and on every crossing; fires at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            period_cnt <= '0;
            cross_cnt  <= '0;
            tmo_cnt    <= '0;
            min_r      <= '0;
            max_r      <= '0;
            o_period   <= '0;
            o_min      <= '0;
            o_max      <= '0;
            o_valid    <= 1'b0;
            o_timeout  <= 1'b0;
        end else begin
            o_valid   <= 1'b0;
            o_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state   <= ST_ARM;
                        tmo_cnt <= TMO_RELOAD;
                    end
                end
                ST_ARM: begin
                    if (rise) begin
                        state      <= ST_MEASURE;
                        period_cnt <= '0;
                        cross_cnt  <= '0;
                        min_r      <= i_data;
                        max_r      <= i_data;
                        tmo_cnt    <= TMO_RELOAD;
                    end else if (tmo_cnt == '0) begin
                        state     <= ST_IDLE;
                        o_timeout <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt - 32'd1;
                    end
                end
                ST_MEASURE: begin
                    period_cnt <= period_inc;
                    min_r      <= min_nxt;
                    max_r      <= max_nxt;
                    // A crossing on the timeout edge takes priority over the abort
                    if (rise) begin
                        tmo_cnt <= TMO_RELOAD;
                        if (cross_cnt == LAST_CROSS) begin
                            state    <= ST_DONE;
                            o_valid  <= 1'b1;
                            o_period <= period_inc;
                            o_min    <= min_nxt;
                            o_max    <= max_nxt;
                        end else begin
                            cross_cnt <= cross_cnt + 8'd1;
                        end
                    end else if (tmo_cnt == '0) begin
                        state     <= ST_IDLE;
                        o_timeout <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt - 32'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sig_meter.sv
// Directed bench for sig_meter: square-wave windows, timeouts, reset abort and boundary cases.
module tb_sig_meter;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [15:0] i_data = '0;
    logic               i_valid = 1'b0;
    logic               i_start = 1'b0;
    logic [31:0]        o_period;
    logic signed [15:0] o_min;
    logic signed [15:0] o_max;
    logic               o_valid;
    logic               o_timeout;
    logic               o_busy;

    int checks = 0;
    int errors = 0;

    int valid_cnt;
    int tmo_cnt;
    int valid_n;
    int tmo_n;
    int cap_period;
    int cap_min;
    int cap_max;
    int first_tmo;
    logic busy_999;

    always #5 clk = ~clk;

    sig_meter #(
        .HYST           (16'sd256),
        .WINDOW_PERIODS (8),
        .TIMEOUT_CYCLES (1000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_data    (i_data),
        .i_valid   (i_valid),
        .i_start   (i_start),
        .o_period  (o_period),
        .o_min     (o_min),
        .o_max     (o_max),
        .o_valid   (o_valid),
        .o_timeout (o_timeout),
        .o_busy    (o_busy)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Square wave of period 100 (high first), except that after the 7th rise the
    // signal stays low until final_at, where it goes high for good.
    function automatic int wave(input int n, input int hi, input int lo, input int final_at);
        if (n < 750) return ((n % 100) < 50) ? hi : lo;
        return (n >= final_at) ? hi : lo;
    endfunction

    task automatic start_meas(input int lo);
        i_data  = 16'(lo);
        i_valid = 1'b1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic run_wave(input int ncyc, input int hi, input int lo, input int final_at,
                            input bit half_valid, input int junk, input int restart_n);
        int v;
        valid_cnt  = 0;
        tmo_cnt    = 0;
        valid_n    = -1;
        tmo_n      = -1;
        cap_period = -1;
        cap_min    = 0;
        cap_max    = 0;
        for (int n = 0; n < ncyc; n++) begin
            v       = wave(n, hi, lo, final_at);
            i_valid = !half_valid || ((n % 2) == 0);
            if (!i_valid && (junk != 0)) v = (v > 0) ? junk : -junk;
            i_data  = 16'(v);
            i_start = (n == restart_n);
            tick();
            if (o_valid) begin
                valid_cnt++;
                valid_n    = n;
                cap_period = int'(o_period);
                cap_min    = int'(o_min);
                cap_max    = int'(o_max);
            end
            if (o_timeout) begin
                tmo_cnt++;
                tmo_n = n;
            end
        end
        i_start = 1'b0;
        i_valid = 1'b1;
    endtask

    // Observation k follows the k-th edge after the i_start edge.
    task automatic run_idle(input int amp);
        tmo_cnt   = 0;
        valid_cnt = 0;
        first_tmo = -1;
        busy_999  = 1'b0;
        for (int k = 1; k <= 1005; k++) begin
            i_valid = 1'b1;
            i_data  = (amp == 0) ? 16'sd0 : 16'(((k % 100) < 50) ? amp : -amp);
            tick();
            if (o_timeout) begin
                tmo_cnt++;
                if (first_tmo < 0) first_tmo = k;
            end
            if (o_valid) valid_cnt++;
            if (k == 999) busy_999 = o_busy;
        end
    endtask

    task automatic check_window(input string tag, input int exp_period, input int exp_min,
                                input int exp_max, input int exp_n);
        check({tag, "_valid_cnt"}, valid_cnt, 1);
        check({tag, "_valid_at"}, valid_n, exp_n);
        check({tag, "_period"}, cap_period, exp_period);
        check({tag, "_min"}, cap_min, exp_min);
        check({tag, "_max"}, cap_max, exp_max);
        check({tag, "_no_timeout"}, tmo_cnt, 0);
        check({tag, "_busy_after"}, 32'(o_busy), 0);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_period", o_period, 0);
        check("rst_min", o_min, 0);
        check("rst_max", o_max, 0);
        check("rst_valid", 32'(o_valid), 0);
        check("rst_timeout", 32'(o_timeout), 0);
        check("rst_busy", 32'(o_busy), 0);
        rst = 1'b0;
        i_data  = -16'sd1000;
        i_valid = 1'b1;
        repeat (5) tick();
        check("idle_busy", 32'(o_busy), 0);

        // Basic +/-1000 square wave window
        start_meas(-1000);
        check("arm_busy", 32'(o_busy), 1);
        run_wave(820, 1000, -1000, 800, 1'b0, 0, -1);
        check_window("sq", 800, -1000, 1000, 800);
        check("sq_hold_period", o_period, 800);

        // Constant zero: timeout only
        start_meas(0);
        run_idle(0);
        check("tmo0_first", first_tmo, 1000);
        check("tmo0_count", tmo_cnt, 1);
        check("tmo0_no_valid", valid_cnt, 0);
        check("tmo0_busy_999", 32'(busy_999), 1);
        check("tmo0_busy_after", 32'(o_busy), 0);
        check("tmo0_period_held", o_period, 800);
        check("tmo0_max_held", o_max, 1000);

        // Wave inside the hysteresis band: no crossings
        start_meas(-200);
        run_idle(200);
        check("tmo200_first", first_tmo, 1000);
        check("tmo200_count", tmo_cnt, 1);
        check("tmo200_no_valid", valid_cnt, 0);
        check("tmo200_min_held", o_min, -1000);

        // Reset halfway through a measurement
        start_meas(-1000);
        run_wave(400, 1000, -1000, 800, 1'b0, 0, -1);
        check("mid_busy", 32'(o_busy), 1);
        #1 rst = 1'b1;
        #1;
        check("arst_period", o_period, 0);
        check("arst_min", o_min, 0);
        check("arst_max", o_max, 0);
        check("arst_busy", 32'(o_busy), 0);
        valid_cnt = 0;
        tmo_cnt   = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (o_valid) valid_cnt++;
            if (o_timeout) tmo_cnt++;
        end
        check("arst_no_valid", valid_cnt, 0);
        check("arst_no_timeout", tmo_cnt, 0);
        rst = 1'b0;
        tick();
        start_meas(-1000);
        run_wave(820, 1000, -1000, 800, 1'b0, 0, -1);
        check_window("after_rst", 800, -1000, 1000, 800);

        // Second i_start during MEASURE is ignored
        start_meas(-1000);
        run_wave(820, 1000, -1000, 800, 1'b0, 0, 300);
        check_window("restart", 800, -1000, 1000, 800);

        // Valid every second cycle, same waveform
        start_meas(-1000);
        run_wave(820, 1000, -1000, 800, 1'b1, 0, -1);
        check_window("half", 800, -1000, 1000, 800);

        // Valid every second cycle with out-of-range junk on invalid cycles
        start_meas(-700);
        run_wave(820, 1500, -700, 800, 1'b1, 7000, -1);
        check_window("junk", 800, -700, 1500, 800);

        // Final crossing lands on the timeout edge: crossing wins
        start_meas(-1000);
        run_wave(1720, 1000, -1000, 1700, 1'b0, 0, -1);
        check_window("tie", 1700, -1000, 1000, 1700);

        // One cycle later the timeout fires first
        start_meas(-1000);
        run_wave(1720, 1000, -1000, 1701, 1'b0, 0, -1);
        check("late_no_valid", valid_cnt, 0);
        check("late_timeout_cnt", tmo_cnt, 1);
        check("late_timeout_at", tmo_n, 1700);
        check("late_period_held", o_period, 1700);
        check("late_busy_after", 32'(o_busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
